// File: rtl/painel_pedidos_tx.sv
// Operator-panel UART transmitter: queues transport requests, merges control commands, sends 8N1 bytes.
// Optional build macro PAINEL_TX_PARIDADE_EN inserts an even-parity bit between data and stop.
//
// state    | meaning
// OCIOSO   | line idle, waiting for a pending command or a queued request
// CARREGA  | latch the next byte (command flags first, else FIFO head)
// START    | start bit, TX low
// DADOS    | 8 data bits, LSB first
// PARIDADE | even parity bit (only with PAINEL_TX_PARIDADE_EN)
// STOP     | stop bit, TX high
module painel_pedidos_tx #(
  parameter int BAUD_DIV     = 434,
  parameter int PROFUNDIDADE = 8,
  parameter int LOG_PROF     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedido_valido,
  input  logic [1:0] pedido_origem,
  input  logic [1:0] pedido_destino,
  input  logic [1:0] pedido_tipo,
  output logic       pedido_pronto,
  output logic       erro_pedido,
  input  logic       cmd_iniciar,
  input  logic       cmd_reset,
  input  logic       cmd_emergencia,
  output logic       TX,
  output logic       ocupado,
  output logic       fila_vazia,
  output logic       fila_cheia,
  output logic [2:0] db_estado
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_FIM = CW'(BAUD_DIV - 1);
  localparam logic [LOG_PROF:0] OCUP_CHEIA = PROFUNDIDADE[LOG_PROF:0];

`ifdef PAINEL_TX_PARIDADE_EN
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CARREGA  = 3'd1,
    START    = 3'd2,
    DADOS    = 3'd3,
    STOP     = 3'd4,
    PARIDADE = 3'd5
  } estado_t;
`else
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    START   = 3'd2,
    DADOS   = 3'd3,
    STOP    = 3'd4
  } estado_t;
`endif

  estado_t estado, estado_prox;

  logic [CW-1:0]       baud_cnt;
  logic [2:0]          bit_cnt, bit_prox;
  logic [7:0]          dado;
  logic                tx_prox;
  logic                baud_fim;

  logic [5:0]          fila [PROFUNDIDADE];
  logic [LOG_PROF-1:0] ptr_esc, ptr_lei;
  logic [LOG_PROF:0]   ocupacao;

  logic                flag_ini, flag_rst, flag_emg;
  logic                tem_flag;
  logic                pedido_ok;
  logic                escreve, le, consome_cmd;
  logic [7:0]          byte_ctrl, byte_pedido;

  assign baud_fim    = (baud_cnt == BAUD_FIM);
  assign tem_flag    = flag_ini | flag_rst | flag_emg;
  assign fila_vazia  = (ocupacao == '0);
  assign fila_cheia  = (ocupacao == OCUP_CHEIA);
  assign pedido_pronto = ~fila_cheia;
  assign ocupado     = (estado != OCIOSO);
  assign db_estado   = estado;

  assign pedido_ok   = (pedido_tipo != 2'b00) && (pedido_origem != pedido_destino);
  assign escreve     = pedido_valido && pedido_pronto && pedido_ok;
  // Command flags win over the FIFO head whenever both are waiting.
  assign consome_cmd = (estado == CARREGA) && tem_flag;
  assign le          = (estado == CARREGA) && !tem_flag && !fila_vazia;

  assign byte_ctrl   = {1'b1, 2'b00, flag_emg, 1'b0, flag_rst, 1'b0, flag_ini};
  assign byte_pedido = {2'b00, fila[ptr_lei]};

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (tem_flag || !fila_vazia) estado_prox = CARREGA;
      CARREGA: estado_prox = START;
      START:   if (baud_fim) estado_prox = DADOS;
`ifdef PAINEL_TX_PARIDADE_EN
      DADOS:    if (baud_fim && bit_cnt == 3'd7) estado_prox = PARIDADE;
      PARIDADE: if (baud_fim) estado_prox = STOP;
`else
      DADOS:   if (baud_fim && bit_cnt == 3'd7) estado_prox = STOP;
`endif
      STOP:    if (baud_fim) estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    bit_prox = bit_cnt;
    if (estado_prox == DADOS && estado != DADOS) begin
      bit_prox = 3'd0;
    end else if (estado == DADOS && baud_fim) begin
      bit_prox = bit_cnt + 3'd1;
    end
  end

  // TX follows the state being entered so the line changes on the same edge as the FSM.
  always_comb begin
    tx_prox = 1'b1;
    case (estado_prox)
      START:    tx_prox = 1'b0;
      DADOS:    tx_prox = dado[bit_prox];
`ifdef PAINEL_TX_PARIDADE_EN
      PARIDADE: tx_prox = ^dado;
`endif
      default:  tx_prox = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      TX       <= 1'b1;
    end else begin
      bit_cnt <= bit_prox;
      TX      <= tx_prox;
      if (estado_prox != estado || baud_fim) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dado <= 8'h00;
    end else if (estado == CARREGA) begin
      dado <= tem_flag ? byte_ctrl : byte_pedido;
    end
  end

  // A pulse landing on the consuming edge survives into the next command byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_ini <= 1'b0;
      flag_rst <= 1'b0;
      flag_emg <= 1'b0;
    end else if (consome_cmd) begin
      flag_ini <= cmd_iniciar;
      flag_rst <= cmd_reset;
      flag_emg <= cmd_emergencia;
    end else begin
      flag_ini <= flag_ini | cmd_iniciar;
      flag_rst <= flag_rst | cmd_reset;
      flag_emg <= flag_emg | cmd_emergencia;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      erro_pedido <= 1'b0;
    end else begin
      erro_pedido <= pedido_valido && pedido_pronto && !pedido_ok;
    end
  end

  always_ff @(posedge clock) begin
    if (escreve) begin
      fila[ptr_esc] <= {pedido_tipo, pedido_destino, pedido_origem};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_esc  <= '0;
      ptr_lei  <= '0;
      ocupacao <= '0;
    end else begin
      if (escreve) ptr_esc <= ptr_esc + 1'b1;
      if (le)      ptr_lei <= ptr_lei + 1'b1;
      case ({escreve, le})
        2'b10:   ocupacao <= ocupacao + 1'b1;
        2'b01:   ocupacao <= ocupacao - 1'b1;
        default: ocupacao <= ocupacao;
      endcase
    end
  end

endmodule

// File: tb/tb_painel_pedidos_tx.sv
// Self-checking bench for painel_pedidos_tx: a line decoder compares every frame on TX
// against a queue of bytes predicted from the request/command encoding rules.
module tb_painel_pedidos_tx;

  localparam int B = 4;
`ifdef PAINEL_TX_PARIDADE_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       pedido_valido;
  logic [1:0] pedido_origem, pedido_destino, pedido_tipo;
  logic       pedido_pronto, erro_pedido;
  logic       cmd_iniciar, cmd_reset, cmd_emergencia;
  logic       TX, ocupado, fila_vazia, fila_cheia;
  logic [2:0] db_estado;

  painel_pedidos_tx #(.BAUD_DIV(B), .PROFUNDIDADE(8), .LOG_PROF(3)) dut (
    .clock(clock), .reset(reset),
    .pedido_valido(pedido_valido), .pedido_origem(pedido_origem),
    .pedido_destino(pedido_destino), .pedido_tipo(pedido_tipo),
    .pedido_pronto(pedido_pronto), .erro_pedido(erro_pedido),
    .cmd_iniciar(cmd_iniciar), .cmd_reset(cmd_reset), .cmd_emergencia(cmd_emergencia),
    .TX(TX), .ocupado(ocupado), .fila_vazia(fila_vazia), .fila_cheia(fila_cheia),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int falhas = 0;
  logic [7:0] esperados[$];
  bit mon_en = 1'b1;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  function automatic logic [7:0] cod(input logic [1:0] o, input logic [1:0] d, input logic [1:0] t);
    return 8'(int'(t) * 16 + int'(d) * 4 + int'(o));
  endfunction

  task automatic ciclo();
    @(posedge clock); #1;
  endtask

  task automatic pedir(input logic [1:0] o, input logic [1:0] d, input logic [1:0] t,
                       input bit esperado_pronto, input bit empilha);
    bit invalido;
    invalido = (t == 2'd0) || (o == d);
    pedido_origem  = o;
    pedido_destino = d;
    pedido_tipo    = t;
    pedido_valido  = 1'b1;
    verifica("pedido_pronto", pedido_pronto, esperado_pronto);
    ciclo();
    pedido_valido = 1'b0;
    verifica("erro_pedido", erro_pedido, invalido && esperado_pronto);
    if (!invalido && esperado_pronto && empilha) esperados.push_back(cod(o, d, t));
  endtask

  task automatic pulsa(input int qual);
    case (qual)
      0: cmd_iniciar = 1'b1;
      1: cmd_reset = 1'b1;
      default: cmd_emergencia = 1'b1;
    endcase
    ciclo();
    cmd_iniciar = 1'b0;
    cmd_reset = 1'b0;
    cmd_emergencia = 1'b0;
  endtask

  task automatic aguarda_estado(input logic [2:0] e);
    int c = 0;
    while (db_estado !== e && c < 200) begin
      ciclo();
      c++;
    end
    verifica("aguarda_estado", db_estado, e);
  endtask

  task automatic esperar_fim(input int limite);
    int c = 0;
    while ((esperados.size() != 0 || ocupado || !fila_vazia) && c < limite) begin
      ciclo();
      c++;
    end
    verifica("dreno_timeout", c < limite, 1);
  endtask

  task automatic valido_aleatorio(output logic [1:0] o, output logic [1:0] d, output logic [1:0] t);
    o = 2'($urandom_range(0, 3));
    d = 2'((int'(o) + int'($urandom_range(1, 3))) % 4);
    t = 2'($urandom_range(1, 3));
  endtask

  // Line decoder: samples TX once per clock and checks each frame bit-by-bit.
  logic       amostras [NB*B];
  logic       tx_ant;
  logic       abortou, forma_ok;
  logic [7:0] dado_rx;

  initial begin : monitor
    tx_ant = 1'b1;
    forever begin
      ciclo();
      if (mon_en && tx_ant === 1'b1 && TX === 1'b0) begin
        abortou = 1'b0;
        amostras[0] = TX;
        for (int j = 1; j < NB*B; j++) begin
          ciclo();
          if (!mon_en) begin
            abortou = 1'b1;
            break;
          end
          amostras[j] = TX;
        end
        if (!abortou) begin
          forma_ok = (amostras[0] === 1'b0) && (amostras[(NB-1)*B] === 1'b1);
          for (int k = 0; k < NB; k++)
            for (int j = 1; j < B; j++)
              if (amostras[k*B+j] !== amostras[k*B]) forma_ok = 1'b0;
          for (int i = 0; i < 8; i++) dado_rx[i] = amostras[(1+i)*B];
          verifica("forma_quadro", forma_ok, 1);
`ifdef PAINEL_TX_PARIDADE_EN
          verifica("paridade", amostras[9*B], ^dado_rx);
`endif
          verifica("quadro_esperado", esperados.size() > 0, 1);
          if (esperados.size() > 0) verifica("byte_quadro", dado_rx, esperados.pop_front());
        end
      end
      tx_ant = TX;
    end
  end

  initial begin : limite_global
    #500000;
    $display("FAIL global_timeout: observado=running esperado=finished");
    $fatal(1, "timeout");
  end

  initial begin : principal
    logic [1:0] o, d, t;
    logic [7:0] b1, b2;
    int c, baixos;

    reset = 1'b1;
    pedido_valido = 1'b0;
    pedido_origem = 2'd0;
    pedido_destino = 2'd0;
    pedido_tipo = 2'd0;
    cmd_iniciar = 1'b0;
    cmd_reset = 1'b0;
    cmd_emergencia = 1'b0;
    repeat (3) ciclo();
    verifica("rst_tx", TX, 1);
    verifica("rst_ocupado", ocupado, 0);
    verifica("rst_fila_vazia", fila_vazia, 1);
    verifica("rst_fila_cheia", fila_cheia, 0);
    verifica("rst_pronto", pedido_pronto, 1);
    verifica("rst_erro", erro_pedido, 0);
    verifica("rst_estado", db_estado, 0);
    reset = 1'b0;
    ciclo();

    // Single request from idle: latency and frame length.
    pedir(2'b01, 2'b10, 2'b11, 1'b1, 1'b1);
    verifica("t1_fila_nao_vazia", fila_vazia, 0);
    verifica("t1_tx_n", TX, 1);
    ciclo();
    verifica("t1_tx_n1", TX, 1);
    verifica("t1_estado_n1", db_estado, 1);
    ciclo();
    verifica("t1_tx_n2", TX, 0);
    verifica("t1_estado_n2", db_estado, 2);
    c = 0;
    do begin
      c++;
      ciclo();
    end while (db_estado !== 3'd0 && c < 500);
    verifica("t1_comprimento", c, NB*B);
    esperar_fim(2000);

    // Rejected requests.
    pedir(2'b10, 2'b10, 2'b01, 1'b1, 1'b1);
    pedir(2'b01, 2'b10, 2'b00, 1'b1, 1'b1);
    ciclo();
    verifica("t2_erro_um_ciclo", erro_pedido, 0);
    verifica("t2_fila_vazia", fila_vazia, 1);
    verifica("t2_tx", TX, 1);
    verifica("t2_estado", db_estado, 0);

    // Fill the FIFO while a command frame is on the line.
    esperados.push_back(8'h90);
    pulsa(2);
    aguarda_estado(3'd3);
    for (int i = 0; i < 8; i++) begin
      valido_aleatorio(o, d, t);
      pedir(o, d, t, 1'b1, 1'b1);
    end
    verifica("t3_fila_cheia", fila_cheia, 1);
    verifica("t3_pronto", pedido_pronto, 0);
    valido_aleatorio(o, d, t);
    pedir(o, d, t, 1'b0, 1'b1);
    verifica("t3_cheia_apos_9", fila_cheia, 1);
    esperar_fim(3000);

    // Merged commands take priority over queued requests.
    valido_aleatorio(o, d, t);
    pedir(o, d, t, 1'b1, 1'b1);
    valido_aleatorio(o, d, t);
    b1 = cod(o, d, t);
    pedir(o, d, t, 1'b1, 1'b0);
    valido_aleatorio(o, d, t);
    b2 = cod(o, d, t);
    pedir(o, d, t, 1'b1, 1'b0);
    esperados.push_back(8'h91);
    esperados.push_back(b1);
    esperados.push_back(b2);
    aguarda_estado(3'd3);
    pulsa(2);
    repeat (3) ciclo();
    pulsa(0);
    esperar_fim(3000);
    esperados.push_back(8'h84);
    pulsa(1);
    esperar_fim(2000);
    repeat (20) ciclo();
    verifica("t4_sem_quadro_extra", db_estado, 0);

    // Reset in the middle of the data bits.
    for (int i = 0; i < 3; i++) begin
      valido_aleatorio(o, d, t);
      pedir(o, d, t, 1'b1, 1'b0);
    end
    aguarda_estado(3'd3);
    mon_en = 1'b0;
    ciclo();
    reset = 1'b1;
    ciclo();
    verifica("t5_tx", TX, 1);
    verifica("t5_estado", db_estado, 0);
    verifica("t5_fila_vazia", fila_vazia, 1);
    verifica("t5_ocupado", ocupado, 0);
    reset = 1'b0;
    baixos = 0;
    for (int i = 0; i < 60; i++) begin
      ciclo();
      if (TX !== 1'b1 || ocupado !== 1'b0) baixos++;
    end
    verifica("t5_sem_quadros", baixos, 0);
    mon_en = 1'b1;

    // Random bursts of valid and invalid requests.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        o = 2'($urandom_range(0, 3));
        d = 2'($urandom_range(0, 3));
        t = 2'($urandom_range(0, 3));
        pedir(o, d, t, 1'b1, 1'b1);
        repeat ($urandom_range(0, 3)) ciclo();
      end
      esperar_fim(4000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
    $finish;
  end

endmodule
